imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 2, legal range 0..15; extra access cycles per fetch.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h01000000; byte address of word 0, equal to the fetch reset PC.
REQ-004 clock  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 addr_in  input  32 (arch_reg)  fetch PC byte address.
REQ-007 flush  input  1  redirect pulse, same signal as the fetch set_PC.
REQ-008 load_en  input  1  backdoor write strobe.
REQ-009 load_addr  input  clog2(DEPTH_WORDS)  backdoor word index.
REQ-010 load_data  input  32  backdoor write data.
REQ-011 data_out  output  32 (arch_reg)  instruction word to fetch data_in.
REQ-012 valid_out  output  1  data_out holds the word for the current PC.
REQ-013 stall_out  output  1  hold PC; drives fetch stall_PC.
REQ-014 fault_out  output  1  access fault, qualified by valid_out.

Function
REQ-015 FSM states: ADDR, WAIT, RESP.
REQ-016 ADDR: stall_out=1; at the clock edge, latch addr_in into addr_q and load cnt<=WAIT_STATES; go to WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT: stall_out=1; decrement cnt; when cnt==1, go to RESP.
REQ-018 On entry to RESP, register data_out from the memory word at index (addr_q-BASE_ADDR)>>2 and register fault_out.
REQ-019 RESP: stall_out=0 and valid_out=1 for exactly one cycle; next state ADDR.
REQ-020 Latency: addr_in sampled -> valid_out after WAIT_STATES+1 cycles; one instruction per WAIT_STATES+2 cycles.
REQ-021 flush=1 in any state: next state ADDR, cnt cleared, and valid_out forced 0 in that cycle; stall_out is unaffected because fetch gives set_PC priority.
REQ-022 Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): data_out=INSTR_NOP (32'h00000013), fault_out=1; the memory is not read.
REQ-023 Address arithmetic SHALL be 32-bit unsigned subtraction; a wrap below BASE_ADDR SHALL count as out of range.
REQ-024 Load write and read to the same word at the same edge: read returns the old data (read-before-write).
REQ-025 data_out and fault_out hold their values outside RESP.

Reset
REQ-026 reset: state=ADDR, cnt=0, addr_q=0, data_out=0, valid_out=0, fault_out=0; stall_out=1 from the first cycle after reset.
REQ-027 reset mid-access SHALL abandon the access with no valid_out pulse.
REQ-028 Memory contents SHALL NOT be reset; load_en SHALL be honoured during reset.

Configuration
REQ-029 Macro IMEM_MISALIGN_CHECK_EN: when defined, addr_q[1:0]!=0 yields data_out=INSTR_NOP and fault_out=1 in RESP.
REQ-030 Without IMEM_MISALIGN_CHECK_EN, addr_q[1:0] SHALL be ignored; the word is read normally and fault_out reflects range only.

Structure
REQ-031 instructions_pkg SHALL hold INSTR_NOP and IMEM_BASE_ADDR; arch_reg SHALL be reused from it.
REQ-032 The FSM state enum SHALL be local to imem_responder.
REQ-033 Sub-module imem_array SHALL implement a DEPTH_WORDS x 32 array with one synchronous read port and one write port.

Verification
REQ-034 WAIT_STATES=2; mem[0]=32'h00500093; release reset with addr_in=32'h01000000 -> stall_out high 3 cycles, then valid_out=1 with data_out=32'h00500093 and fault_out=0.
REQ-035 Sequential fetch with WAIT_STATES=0 -> a valid_out pulse every 2 cycles; PC 0x01000000, 0x01000004 and 0x01000008 return mem[0], mem[1] and mem[2].
REQ-036 flush asserted in a WAIT cycle with new addr_in=32'h01000010 -> no valid_out for the old address; the next valid_out returns mem[4].
REQ-037 addr_in=32'h00FFFFFC and addr_in=32'h01001000 (DEPTH_WORDS=1024) -> valid_out with data_out=32'h00000013 and fault_out=1.
REQ-038 addr_in=32'h01000002 -> fault_out=1 and NOP with IMEM_MISALIGN_CHECK_EN defined; mem[0] and fault_out=0 without it.
REQ-039 reset asserted in WAIT -> next cycle state=ADDR, valid_out=0, data_out=0, stall_out=1.

Source files
------------

// File: rtl/instructions_pkg.sv
// Shared instruction-side types and constants for the fetch path.
package instructions_pkg;

   typedef logic [31:0] arch_reg;

   localparam arch_reg INSTR_NOP      = 32'h00000013;
   localparam arch_reg IMEM_BASE_ADDR = 32'h01000000;

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 instruction store: one synchronous read port, one write port.
module imem_array
   import instructions_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output arch_reg       rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  arch_reg       wr_data
);

   arch_reg mem [DEPTH_WORDS];

   // Storage is never reset so backdoor loads work while the core is held in reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Same-edge read of a word being written returns the old contents.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder with configurable wait states.
// Optional build macro IMEM_MISALIGN_CHECK_EN faults fetches whose PC is not word aligned.
module imem_responder
   import instructions_pkg::*;
#(
   parameter int      DEPTH_WORDS = 1024,
   parameter int      WAIT_STATES = 2,
   parameter arch_reg BASE_ADDR   = IMEM_BASE_ADDR
) (
   input  logic                           clock,
   input  logic                           reset,
   input  arch_reg                        addr_in,
   input  logic                           flush,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  arch_reg                        load_data,
   output arch_reg                        data_out,
   output logic                           valid_out,
   output logic                           stall_out,
   output logic                           fault_out
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ADDR, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   arch_reg       addr_q;
   arch_reg       rd_pc;
   arch_reg       offset;
   arch_reg       rd_data;
   logic          in_range;
   logic          bad_align;
   logic          access_fault;
   logic          to_resp;
   logic          rd_en;
   logic [AW-1:0] rd_idx;

   // With zero wait states the read fires on the sampling edge, so index from addr_in directly.
   assign rd_pc    = (state == ADDR) ? addr_in : addr_q;
   assign offset   = rd_pc - BASE_ADDR;
   assign in_range = {1'b0, offset} < SPAN;
   assign rd_idx   = offset[AW+1:2];

`ifdef IMEM_MISALIGN_CHECK_EN
   assign bad_align = (rd_pc[1:0] != 2'b00);
`else
   assign bad_align = 1'b0;
`endif

   assign access_fault = !in_range || bad_align;

   assign to_resp = !flush &&
                    (((state == ADDR) && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1)));
   assign rd_en   = to_resp && !access_fault;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ADDR;
         cnt       <= '0;
         addr_q    <= '0;
         fault_out <= 1'b0;
      end else begin
         if (flush) begin
            state <= ADDR;
            cnt   <= '0;
         end else begin
            case (state)
               ADDR: begin
                  addr_q <= addr_in;
                  cnt    <= CNT_LOAD;
                  state  <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
               WAIT: begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state <= RESP;
                  end
               end
               RESP:    state <= ADDR;
               default: state <= ADDR;
            endcase
         end
         if (to_resp) begin
            fault_out <= access_fault;
         end
      end
   end

   // A faulted fetch never reads the array, so the NOP substitution keys off the fault flag.
   assign data_out  = fault_out ? INSTR_NOP : rd_data;
   assign valid_out = (state == RESP) && !flush;
   assign stall_out = (state != RESP);

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (rd_en),
      .rd_addr (rd_idx),
      .rd_data (rd_data),
      .wr_en   (load_en),
      .wr_addr (load_addr),
      .wr_data (load_data)
   );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: one responder with two wait states, one with none, sharing the load bus.
module tb_imem_responder;

   logic        clock = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   logic [31:0] addr_a = '0;
   logic [31:0] addr_b = '0;
   logic        flush_a = 1'b0;
   logic        flush_b = 1'b0;
   logic        load_en = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [31:0] load_data = '0;

   logic [31:0] data_a, data_b;
   logic        valid_a, valid_b, stall_a, stall_b, fault_a, fault_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] img [0:7];

   always #5 clock = ~clock;

   imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h01000000)) dut_a (
      .clock(clock), .reset(rst_a), .addr_in(addr_a), .flush(flush_a),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .data_out(data_a), .valid_out(valid_a), .stall_out(stall_a), .fault_out(fault_a)
   );

   imem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h01000000)) dut_b (
      .clock(clock), .reset(rst_b), .addr_in(addr_b), .flush(flush_b),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .data_out(data_b), .valid_out(valid_b), .stall_out(stall_b), .fault_out(fault_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Entered and left one tick after an edge with dut_b in ADDR.
   task automatic fetch_b(input string tag, input logic [31:0] pc,
                          input logic [31:0] exp_data, input logic exp_fault);
      addr_b = pc;
      #1;
      check({tag, "_idle_valid"}, 32'(valid_b), 32'd0);
      check({tag, "_idle_stall"}, 32'(stall_b), 32'd1);
      step();
      #1;
      check({tag, "_valid"}, 32'(valid_b), 32'd1);
      check({tag, "_stall"}, 32'(stall_b), 32'd0);
      check({tag, "_data"},  data_b, exp_data);
      check({tag, "_fault"}, 32'(fault_b), 32'(exp_fault));
      step();
   endtask

   initial begin
      img[0] = 32'h00500093;
      img[1] = 32'h00100113;
      img[2] = 32'h00200193;
      img[3] = 32'h00300213;
      img[4] = 32'h00400293;
      img[5] = 32'h00500313;
      img[6] = 32'h00600393;
      img[7] = 32'h00700413;

      // Backdoor load while both responders are held in reset.
      step();
      for (int i = 0; i < 8; i++) begin
         load_en = 1'b1; load_addr = 10'(i); load_data = img[i];
         step();
      end
      load_en = 1'b1; load_addr = 10'd1023; load_data = 32'hDEADBEEF;
      step();
      load_en = 1'b0;
      #1;
      check("rst_data",  data_a, 32'h0);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_fault", 32'(fault_a), 32'd0);
      check("rst_stall", 32'(stall_a), 32'd1);

      // First fetch after reset release, two wait states.
      step();
      addr_a = 32'h01000000;
      rst_a  = 1'b0;
      #1;
      check("a0_stall_c0", 32'(stall_a), 32'd1);
      check("a0_valid_c0", 32'(valid_a), 32'd0);
      step(); #1;
      check("a0_stall_c1", 32'(stall_a), 32'd1);
      check("a0_valid_c1", 32'(valid_a), 32'd0);
      step(); #1;
      check("a0_stall_c2", 32'(stall_a), 32'd1);
      check("a0_valid_c2", 32'(valid_a), 32'd0);
      step(); #1;
      check("a0_valid", 32'(valid_a), 32'd1);
      check("a0_stall", 32'(stall_a), 32'd0);
      check("a0_data",  data_a, img[0]);
      check("a0_fault", 32'(fault_a), 32'd0);
      addr_a = 32'h01000008;
      step(); #1;
      check("a0_after_valid", 32'(valid_a), 32'd0);
      check("a0_after_stall", 32'(stall_a), 32'd1);
      check("a0_hold_data",   data_a, img[0]);

      // Redirect during WAIT: the fetch of 0x...08 must never respond.
      step();
      flush_a = 1'b1;
      addr_a  = 32'h01000010;
      #1;
      check("fl_valid_w", 32'(valid_a), 32'd0);
      step();
      flush_a = 1'b0;
      #1;
      check("fl_valid_a", 32'(valid_a), 32'd0);
      check("fl_stall_a", 32'(stall_a), 32'd1);
      step(); #1;
      check("fl_valid_w1", 32'(valid_a), 32'd0);
      step(); #1;
      check("fl_valid_w2", 32'(valid_a), 32'd0);
      step(); #1;
      check("fl_valid", 32'(valid_a), 32'd1);
      check("fl_data",  data_a, img[4]);
      check("fl_fault", 32'(fault_a), 32'd0);

      // Redirect in RESP suppresses that cycle's valid pulse.
      step(); step(); step(); step();
      flush_a = 1'b1;
      #1;
      check("flr_valid", 32'(valid_a), 32'd0);
      check("flr_stall", 32'(stall_a), 32'd0);
      step();
      flush_a = 1'b0;
      #1;
      check("flr_next_stall", 32'(stall_a), 32'd1);
      check("flr_next_valid", 32'(valid_a), 32'd0);

      // Reset mid-access.
      step();
      rst_a = 1'b1;
      step(); #1;
      check("rw_valid", 32'(valid_a), 32'd0);
      check("rw_data",  data_a, 32'h0);
      check("rw_fault", 32'(fault_a), 32'd0);
      check("rw_stall", 32'(stall_a), 32'd1);
      step(); #1;
      check("rw_valid2", 32'(valid_a), 32'd0);

      // Zero wait states: back-to-back sequential fetch and boundary addresses.
      rst_b = 1'b0;
      fetch_b("b0", 32'h01000000, img[0], 1'b0);
      fetch_b("b1", 32'h01000004, img[1], 1'b0);
      fetch_b("b2", 32'h01000008, img[2], 1'b0);
      fetch_b("below", 32'h00FFFFFC, 32'h00000013, 1'b1);
      fetch_b("above", 32'h01001000, 32'h00000013, 1'b1);
      fetch_b("last",  32'h01000FFC, 32'hDEADBEEF, 1'b0);
      fetch_b("wrap",  32'h00000000, 32'h00000013, 1'b1);
`ifdef IMEM_MISALIGN_CHECK_EN
      fetch_b("misal", 32'h01000002, 32'h00000013, 1'b1);
`else
      fetch_b("misal", 32'h01000002, img[0], 1'b0);
`endif

      // Load and fetch of the same word on the same edge sees the old word.
      addr_b    = 32'h01000014;
      load_en   = 1'b1;
      load_addr = 10'd5;
      load_data = 32'hCAFEF00D;
      step();
      load_en = 1'b0;
      #1;
      check("rbw_valid", 32'(valid_b), 32'd1);
      check("rbw_old",   data_b, img[5]);
      step();
      fetch_b("rbw_new", 32'h01000014, 32'hCAFEF00D, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
